msrh_ldq_issue_sched: RTL
=========================

Name: msrh_ldq_issue_sched

Overview:
- Age-ordered issue scheduler for the load queue. Sits directly downstream of the per-entry LDQ state machines.
- Inputs: each entry's ready flag and LSU-pipe one-hot.
- Per LSU pipe and per cycle, selects the oldest ready entry. Returns a per-entry picked pulse, which drives each entry's i_entry_picked.
- Registers the selected entry index into the pipe's EX0 stage.
- Age is tracked with an LDQ_SIZE x LDQ_SIZE age matrix, updated on allocation and release.

Parameters:
LDQ_SIZE, 16, number of LDQ entries
LSU_INST_NUM, 2, number of LSU pipes
IDX_W, $clog2(LDQ_SIZE), width of entry index

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_alloc_vld  in  LDQ_SIZE  entries dispatched this cycle (multi-hot)
i_alloc_ptr  in  IDX_W  index of the oldest entry allocated this cycle
i_release  in  LDQ_SIZE  entries freed this cycle (from entry finish)
i_entry_ready  in  LDQ_SIZE  per-entry operand/state ready
i_entry_pipe_oh  in  LDQ_SIZE*LSU_INST_NUM  per-entry pipe one-hot; entry e at bits [e*LSU_INST_NUM +: LSU_INST_NUM]
i_pipe_stall  in  LSU_INST_NUM  pipe p cannot accept an issue this cycle
i_ex0_kill  in  LSU_INST_NUM  kill the registered EX0 issue of pipe p (flush)
o_picked  out  LDQ_SIZE  combinational grant pulse to entries
o_ex0_valid  out  LSU_INST_NUM  registered issue valid per pipe
o_ex0_idx  out  LSU_INST_NUM*IDX_W  registered issued entry index per pipe

Behaviour:
- Reset is asynchronous, active-low (i_reset_n); clock is i_clk.
- Reset values: valid vector = 0, age matrix = 0, o_ex0_valid = 0, o_ex0_idx = 0. o_picked is 0 while no entry is valid.
- State:
  - r_valid[LDQ_SIZE].
  - r_age[i][j] = 1 means entry i is older than entry j.
  - The diagonal is always 0.
- Allocation of entry i:
  - Next-cycle row i = 0, except that bits are set for same-cycle allocations that are younger than i.
  - Next-cycle column i: r_age[j][i] = 1 for every j with post-release valid = 1.
  - Among same-cycle allocations, order is ascending modulo-LDQ_SIZE distance from i_alloc_ptr. Wrap-around is required: with ptr = 14 and entries 14, 15, 0 allocated, 14 is oldest and 0 is youngest.
  - r_valid[i] <= 1.
- Release of entry i: r_valid[i] <= 0; row i and column i are cleared.
- Release and allocation of different entries in the same cycle: release is applied first.
- Release and allocation of the same entry in the same cycle is illegal; behaviour is undefined.
- Candidates: cand_p[e] = r_valid[e] & i_entry_ready[e] & i_entry_pipe_oh[e][p].
- Grant: grant_p[e] = cand_p[e] & ~i_pipe_stall[p] & no j with cand_p[j] & r_age[j][e].
- Grant is one-hot or zero.
- o_picked = OR over p of grant_p. It is combinational in the same cycle as ready.
- EX0 register:
  - o_ex0_valid[p] <= |grant_p & ~i_ex0_kill[p].
  - o_ex0_idx[p] <= encode(grant_p) when |grant_p; otherwise it holds its previous value.
- Latency: ready in cycle N -> o_picked in cycle N -> o_ex0_valid in cycle N+1.
- Stall: no grant and no picked pulse for that pipe. o_ex0_valid[p] = 0 in the next cycle; the entry stays ready and retries.
- Kill: an asserted i_ex0_kill[p] only suppresses the EX0 valid being loaded that cycle. The entry-side flush is handled by the entries.
- An entry allocated in cycle N is not a candidate until cycle N+1, because r_valid is registered.
- Full queue (all valid): the matrix remains a total order and exactly one oldest candidate exists per pipe.

Optional Feature:
MSRH_LDQ_AGE_CHECK_EN:
- Defined: adds simulation checks each cycle; any violation calls $fatal with the offending indices. Checked conditions:
  - For every valid pair i != j, r_age[i][j] XOR r_age[j][i] = 1.
  - Entries with r_valid = 0 have all-zero rows and columns.
  - grant_p is $onehot0.
  - i_alloc_vld & r_valid & ~i_release = 0.
  - i_alloc_vld & i_release = 0.
- Undefined: no check logic; functional behaviour is identical.

Test Plan:
- Ordered allocation: allocate 3, then 1, then 7 in consecutive cycles; all ready on pipe 0 -> o_picked = 0x0008, then o_ex0_idx[0] = 3 one cycle later. After 3 is released, 1 is picked, then 7.
- Same-cycle wrap: i_alloc_ptr = 14, allocate 14, 15, 0 together; all ready on pipe 1 -> picks in order 14, 15, 0. Each pick is followed by release of that entry.
- Dual pipe: entries 2 (pipe 0) and 5 (pipe 1) ready together -> o_picked = 0x0024; next cycle o_ex0_valid = 2'b11, idx = {5, 2}.
- Stall: pipe 0 stalled for 2 cycles with entry 4 ready -> o_picked = 0 and o_ex0_valid[0] = 0 for both cycles. Entry 4 is picked on the first unstalled cycle.
- Kill: grant of entry 6 on pipe 0 with i_ex0_kill[0] = 1 -> o_picked[6] = 1, next cycle o_ex0_valid[0] = 0.
- Reset mid-operation: assert i_reset_n = 0 with 10 valid entries and an EX0 valid -> o_ex0_valid = 0 immediately. After release of reset, ready inputs produce no pick until re-allocation.

Source files
------------

// File: rtl/msrh_ldq_issue_sched.sv
// Load-queue issue scheduler: picks the oldest ready entry per LSU pipe using an age matrix.
// Optional simulation consistency checks are enabled by defining MSRH_LDQ_AGE_CHECK_EN.
module msrh_ldq_issue_sched #(
  parameter int unsigned LDQ_SIZE     = 16,
  parameter int unsigned LSU_INST_NUM = 2,
  parameter int unsigned IDX_W        = $clog2(LDQ_SIZE)
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic [LDQ_SIZE-1:0]              i_alloc_vld,
  input  logic [IDX_W-1:0]                 i_alloc_ptr,
  input  logic [LDQ_SIZE-1:0]              i_release,
  input  logic [LDQ_SIZE-1:0]              i_entry_ready,
  input  logic [LDQ_SIZE*LSU_INST_NUM-1:0] i_entry_pipe_oh,
  input  logic [LSU_INST_NUM-1:0]          i_pipe_stall,
  input  logic [LSU_INST_NUM-1:0]          i_ex0_kill,
  output logic [LDQ_SIZE-1:0]              o_picked,
  output logic [LSU_INST_NUM-1:0]          o_ex0_valid,
  output logic [LSU_INST_NUM*IDX_W-1:0]    o_ex0_idx
);

  logic [LDQ_SIZE-1:0]           r_valid_q, r_valid_d;
  logic [LDQ_SIZE-1:0]           r_age_q [LDQ_SIZE];
  logic [LDQ_SIZE-1:0]           r_age_d [LDQ_SIZE];
  logic [LDQ_SIZE-1:0]           valid_rel;
  logic [LDQ_SIZE-1:0]           cand  [LSU_INST_NUM];
  logic [LDQ_SIZE-1:0]           grant [LSU_INST_NUM];
  logic [LSU_INST_NUM-1:0]       ex0_valid_q, ex0_valid_d;
  logic [LSU_INST_NUM*IDX_W-1:0] ex0_idx_q, ex0_idx_d;

  // Modulo distance from the allocation pointer; a larger distance means younger.
  function automatic logic [IDX_W:0] alloc_dist(input logic [IDX_W-1:0] e,
                                                input logic [IDX_W-1:0] ptr);
    if (e >= ptr) return {1'b0, e} - {1'b0, ptr};
    else          return {1'b0, e} + (IDX_W+1)'(LDQ_SIZE) - {1'b0, ptr};
  endfunction

  // Release is applied first, then allocations are ordered behind all survivors.
  always_comb begin
    valid_rel = r_valid_q & ~i_release;
    r_valid_d = valid_rel | i_alloc_vld;
    for (int i = 0; i < LDQ_SIZE; i++) begin
      r_age_d[i] = r_age_q[i] & valid_rel & {LDQ_SIZE{valid_rel[i]}};
    end
    for (int i = 0; i < LDQ_SIZE; i++) begin
      if (i_alloc_vld[i]) begin
        for (int j = 0; j < LDQ_SIZE; j++) begin
          if (i_alloc_vld[j]) begin
            r_age_d[i][j] = (i != j) &&
              (alloc_dist(IDX_W'(j), i_alloc_ptr) > alloc_dist(IDX_W'(i), i_alloc_ptr));
          end else begin
            r_age_d[i][j] = 1'b0;
            r_age_d[j][i] = valid_rel[j];
          end
        end
      end
    end
  end

  // Per-pipe oldest-ready selection and EX0 next-state.
  always_comb begin
    o_picked    = '0;
    ex0_valid_d = '0;
    ex0_idx_d   = ex0_idx_q;
    for (int p = 0; p < LSU_INST_NUM; p++) begin
      for (int e = 0; e < LDQ_SIZE; e++) begin
        cand[p][e] = r_valid_q[e] & i_entry_ready[e] & i_entry_pipe_oh[e*LSU_INST_NUM + p];
      end
      for (int e = 0; e < LDQ_SIZE; e++) begin
        logic blk;
        blk = 1'b0;
        for (int j = 0; j < LDQ_SIZE; j++) begin
          blk = blk | (cand[p][j] & r_age_q[j][e]);
        end
        grant[p][e] = cand[p][e] & ~i_pipe_stall[p] & ~blk;
        if (grant[p][e]) ex0_idx_d[p*IDX_W +: IDX_W] = IDX_W'(e);
      end
      o_picked       = o_picked | grant[p];
      ex0_valid_d[p] = (|grant[p]) & ~i_ex0_kill[p];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid_q   <= '0;
      ex0_valid_q <= '0;
      ex0_idx_q   <= '0;
      for (int i = 0; i < LDQ_SIZE; i++) r_age_q[i] <= '0;
    end else begin
      r_valid_q   <= r_valid_d;
      ex0_valid_q <= ex0_valid_d;
      ex0_idx_q   <= ex0_idx_d;
      for (int i = 0; i < LDQ_SIZE; i++) r_age_q[i] <= r_age_d[i];
    end
  end

  assign o_ex0_valid = ex0_valid_q;
  assign o_ex0_idx   = ex0_idx_q;

`ifdef MSRH_LDQ_AGE_CHECK_EN
  // Structural consistency of the age matrix and the allocation/release interface.
  always @(posedge i_clk) begin
    if (i_reset_n) begin
      for (int i = 0; i < LDQ_SIZE; i++) begin
        if (r_age_q[i][i]) $fatal(1, "age diagonal set at %0d", i);
        for (int j = 0; j < LDQ_SIZE; j++) begin
          if (i != j && r_valid_q[i] && r_valid_q[j] && !(r_age_q[i][j] ^ r_age_q[j][i]))
            $fatal(1, "age order broken between %0d and %0d", i, j);
          if (!r_valid_q[i] && (r_age_q[i][j] || r_age_q[j][i]))
            $fatal(1, "invalid entry %0d has age bits with %0d", i, j);
        end
        if (i_alloc_vld[i] && r_valid_q[i] && !i_release[i])
          $fatal(1, "allocation of live entry %0d", i);
        if (i_alloc_vld[i] && i_release[i])
          $fatal(1, "allocation and release of entry %0d together", i);
      end
      for (int p = 0; p < LSU_INST_NUM; p++) begin
        if (!$onehot0(grant[p])) $fatal(1, "pipe %0d grant not onehot0: %h", p, grant[p]);
      end
    end
  end
`endif

endmodule
